cam_capture_ctrl: RTL
=====================

Name: cam_capture_ctrl

Overview:
Sequences capture of one or more RGB565 frames from the parallel camera bus into the dual-port frame-buffer RAM as RGB332.
- Pairs camera bytes into pixels and generates write address and write enable with a running counter (no multiplier).
- Arms on a start request and signals frame completion and geometry errors to the downstream image processor.
- Sits between the camera GPIO pins and the M9K write port, clocked by the 24 MHz camera clock.

Parameters:
WIDTH, 176, pixels per line written to memory
HEIGHT, 144, lines per frame written to memory
ADDR_W, 15, write address width

Ports:
CLK  in  1  camera-synchronous clock (24 MHz)
RESET_N  in  1  asynchronous, active-low reset
START  in  1  one-cycle pulse; arms capture when idle
CONTINUOUS  in  1  level; 1 = re-arm after each frame
CAM_VSYNC  in  1  high pulse marks frame boundary
CAM_HREF  in  1  high while line bytes valid
CAM_D  in  8  camera data byte
W_ADDR  out  ADDR_W  frame-buffer write address
W_DATA  out  8  RGB332 pixel
W_EN  out  1  write strobe, one cycle per pixel
BUSY  out  1  high in any state except IDLE
FRAME_DONE  out  1  one-cycle pulse at frame end
FRAME_ERR  out  1  sticky; line or frame geometry mismatch
FRAME_CNT  out  8  completed frames, wraps 255->0

Behaviour:
- Reset values: W_ADDR=0, W_DATA=0, W_EN=0, BUSY=0, FRAME_DONE=0, FRAME_ERR=0, FRAME_CNT=0, state=IDLE, x=y=0, byte phase=0.
- Input stage: CAM_VSYNC, CAM_HREF and CAM_D are registered once. Edge detection uses registered vs. previous-registered values.
- States:
  - IDLE: START -> SYNC, and FRAME_ERR is cleared. START while not in IDLE is ignored.
  - SYNC: wait for a VSYNC rising edge -> VBLANK. A mid-frame arm never writes a partial frame.
  - VBLANK: wait for a VSYNC falling edge -> CAPTURE, with x=0, y=0, addr=0, phase=0.
  - CAPTURE:
    - HREF rising edge: phase=0.
    - While HREF is high, bytes alternate:
      - phase 0: latch byte0 (format RRRRRGGG).
      - phase 1: byte1 (format GGGBBBBB) forms W_DATA={byte0[7:5], byte0[2:0], byte1[4:3]}.
    - Write condition: W_EN is asserted only if x<WIDTH and y<HEIGHT. In that case W_ADDR=addr, then addr++.
    - x++ on every phase-1 byte.
    - Latency: the phase-1 byte on the pins at edge n gives W_EN high during the cycle after edge n+1.
  - Line end (HREF falling edge):
    - If x!=WIDTH, FRAME_ERR=1.
    - If phase=1 (odd byte count), FRAME_ERR=1 and the dangling byte is dropped.
    - y++, x=0. addr is not recomputed; writes beyond WIDTH are suppressed, so addr stays y*WIDTH.
  - Frame end (VSYNC rising edge in CAPTURE):
    - If y!=HEIGHT, FRAME_ERR=1.
    - FRAME_DONE pulse, FRAME_CNT++.
    - CONTINUOUS=1 -> VBLANK; else -> IDLE. CONTINUOUS is sampled only at this edge.
- Overflow: x and y saturate at WIDTH and HEIGHT. Excess pixels and lines produce no writes, but still flag FRAME_ERR at the checks above.
- W_EN is never high outside CAPTURE. W_ADDR holds its last value when W_EN=0.
- Simultaneous HREF fall and VSYNC rise in the same cycle: line-end processing happens first, then frame end, both in that cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately (async). No write is issued after reset deassertion until a new START.

Decomposition:
- Shared package cam_pkg:
  - state encoding (IDLE, SYNC, VBLANK, CAPTURE);
  - default WIDTH/HEIGHT constants;
  - RGB565->RGB332 conversion function.
- One sub-module: cam_edge_sync, holding the input register stage plus rise/fall detection for VSYNC and HREF.
- FSM, counters and address generation stay in the top.

Test Plan:
- Reset, START, then one ideal 176x144 frame (VSYNC pulse, 144 HREF lines of 352 bytes) -> exactly 25344 W_EN pulses; addresses 0..25343 in order; one FRAME_DONE; FRAME_CNT=1; FRAME_ERR=0; returns to IDLE.
- Byte pair 0xE0, 0x00 -> W_DATA=0xE0. Pair 0x07, 0xE0 -> W_DATA=0x1C. Pair 0x00, 0x1F -> W_DATA=0x03. Each appears one cycle after the registered second byte.
- START issued while HREF toggles mid-frame -> no W_EN until after the next full VSYNC pulse; the next frame is written from address 0.
- Line of 180 pixels, then a frame of 150 lines -> no write beyond x=175 or y=143; last address 25343; FRAME_ERR=1; FRAME_DONE still pulses.
- CONTINUOUS=1 for three frames, dropped during frame 3 -> FRAME_CNT=3, three FRAME_DONE pulses, BUSY falls after the third frame.
- RESET_N pulsed low at line 70 -> all outputs zero immediately; no writes until the next START and VSYNC.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera capture path: FSM encoding,
// default frame geometry and the RGB565 -> RGB332 pixel packing.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_VBLANK  = 2'd2,
    ST_CAPTURE = 2'd3
  } cam_state_t;

  localparam int CAM_WIDTH  = 176;
  localparam int CAM_HEIGHT = 144;

  // byte0 = RRRRRGGG, byte1 = GGGBBBBB (camera order)
  function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] byte0,
                                                  input logic [7:0] byte1);
    return {byte0[7:5], byte0[2:0], byte1[4:3]};
  endfunction

endpackage

// File: rtl/cam_edge_sync.sv
// Single register stage on the camera pins plus rise/fall detection of
// VSYNC and HREF (registered value versus previous registered value).
module cam_edge_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] d,
  output logic       href_q,
  output logic [7:0] d_q,
  output logic       vs_rise,
  output logic       vs_fall,
  output logic       href_rise,
  output logic       href_fall
);

  logic vs_q;
  logic vs_p;
  logic href_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      vs_p   <= 1'b0;
      href_q <= 1'b0;
      href_p <= 1'b0;
      d_q    <= 8'd0;
    end else begin
      vs_q   <= vsync;
      vs_p   <= vs_q;
      href_q <= href;
      href_p <= href_q;
      d_q    <= d;
    end
  end

  assign vs_rise   = vs_q & ~vs_p;
  assign vs_fall   = ~vs_q & vs_p;
  assign href_rise = href_q & ~href_p;
  assign href_fall = ~href_q & href_p;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Captures RGB565 camera frames into the frame buffer as RGB332: pairs bytes
// into pixels, generates a running write address and reports frame status.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH  = CAM_WIDTH,
  parameter int HEIGHT = CAM_HEIGHT,
  parameter int ADDR_W = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              CONTINUOUS,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_D,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR,
  output logic [7:0]        FRAME_CNT,
  output cam_state_t        dbg_state
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT);

  logic       href_q, vs_rise, vs_fall, href_rise, href_fall;
  logic [7:0] d_q;

  cam_edge_sync u_sync (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .vsync    (CAM_VSYNC),
    .href     (CAM_HREF),
    .d        (CAM_D),
    .href_q   (href_q),
    .d_q      (d_q),
    .vs_rise  (vs_rise),
    .vs_fall  (vs_fall),
    .href_rise(href_rise),
    .href_fall(href_fall)
  );

  cam_state_t        state, state_n;
  logic [XW-1:0]     x, x_n;
  logic [YW-1:0]     y, y_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              phase, phase_n;
  logic [7:0]        byte0, byte0_n;
  logic              line_ovf, line_ovf_n;
  logic              frame_ovf, frame_ovf_n;
  logic [ADDR_W-1:0] w_addr_n;
  logic [7:0]        w_data_n, cnt_n;
  logic              w_en_n, done_n, err_n;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      phase      <= 1'b0;
      byte0      <= 8'd0;
      line_ovf   <= 1'b0;
      frame_ovf  <= 1'b0;
      W_ADDR     <= '0;
      W_DATA     <= 8'd0;
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      FRAME_CNT  <= 8'd0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      addr       <= addr_n;
      phase      <= phase_n;
      byte0      <= byte0_n;
      line_ovf   <= line_ovf_n;
      frame_ovf  <= frame_ovf_n;
      W_ADDR     <= w_addr_n;
      W_DATA     <= w_data_n;
      W_EN       <= w_en_n;
      FRAME_DONE <= done_n;
      FRAME_ERR  <= err_n;
      FRAME_CNT  <= cnt_n;
    end
  end

  // W_EN is a one-cycle write strobe with no backpressure; W_ADDR/W_DATA are
  // only meaningful in a cycle where W_EN is high and hold otherwise.
  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    addr_n      = addr;
    phase_n     = phase;
    byte0_n     = byte0;
    line_ovf_n  = line_ovf;
    frame_ovf_n = frame_ovf;
    w_addr_n    = W_ADDR;
    w_data_n    = W_DATA;
    w_en_n      = 1'b0;
    done_n      = 1'b0;
    err_n       = FRAME_ERR;
    cnt_n       = FRAME_CNT;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_n = ST_SYNC;
          err_n   = 1'b0;
        end
      end
      ST_SYNC: begin
        if (vs_rise) state_n = ST_VBLANK;
      end
      ST_VBLANK: begin
        if (vs_fall) begin
          state_n     = ST_CAPTURE;
          x_n         = '0;
          y_n         = '0;
          addr_n      = '0;
          phase_n     = 1'b0;
          line_ovf_n  = 1'b0;
          frame_ovf_n = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (href_q) begin
          // the byte arriving with the HREF rising edge always starts a pixel
          if (href_rise || !phase) begin
            byte0_n = d_q;
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            if (x < X_MAX && y < Y_MAX && !vs_rise) begin
              w_en_n   = 1'b1;
              w_addr_n = addr;
              w_data_n = rgb565_to_rgb332(byte0, d_q);
              addr_n   = addr + ADDR_W'(1);
            end
            if (x < X_MAX) x_n = x + XW'(1);
            else           line_ovf_n = 1'b1;
          end
        end
        if (href_fall) begin
          if (x != X_MAX || line_ovf || phase) err_n = 1'b1;
          phase_n    = 1'b0;
          x_n        = '0;
          line_ovf_n = 1'b0;
          if (y < Y_MAX) y_n = y + YW'(1);
          else           frame_ovf_n = 1'b1;
        end
        // frame end sees the line count already updated by a coincident line end
        if (vs_rise) begin
          if (y_n != Y_MAX || frame_ovf_n) err_n = 1'b1;
          done_n  = 1'b1;
          cnt_n   = FRAME_CNT + 8'd1;
          state_n = CONTINUOUS ? ST_VBLANK : ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign BUSY      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule
